blocking_port_arbiter: RTL and testbench
========================================

Name: blocking_port_arbiter

Overview:
- Shares one downstream blocking output port (data + notify/sync handshake) between N_REQ upstream blocking-write requesters.
- Each requester presents data with a notify. The arbiter grants round-robin, forwards the held word downstream, and returns a one-cycle sync to the winner once the downstream side accepts.
- Sits between generated modules' blocking outputs and a single shared consumer.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_W, 32, data width (matches integer ports)
CNT_W, 16, width of completed-transfer counter

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-low reset: sampled on posedge clk, reset when 0
req_data  input  N_REQ*DATA_W  requester data, slice i = requester i
req_notify  input  N_REQ  requester i has a valid word; held until its req_sync
req_sync  output  N_REQ  one-cycle pulse to requester i: its word was consumed
out_data  output  DATA_W  forwarded word
out_notify  output  1  out_data valid, held until accepted
out_sync  input  1  downstream ready; transfer completes on a cycle with out_notify=1 and out_sync=1
grant_id  output  clog2(N_REQ)  index of current/last grant
busy  output  1  1 in SEND or ACK
xfer_count  output  CNT_W  completed transfers, wraps modulo 2^CNT_W

Behaviour:
- All outputs registered.
- Reset (rst=0 at posedge) forces:
  - state=IDLE
  - out_notify=0, out_data=0
  - req_sync=0
  - grant_id=0
  - rr pointer=0
  - xfer_count=0
  - busy=0
- Reset mid-transfer abandons the word: no req_sync pulse, no count increment.
- State IDLE:
  - If no req_notify bit is set, stay in IDLE.
  - Otherwise select the first set bit searching upward from the rr pointer, wrapping from N_REQ-1 to 0.
  - Latch grant_id=g and out_data=req_data[g]; set out_notify=1; go to SEND.
- State SEND:
  - out_notify=1 and out_data stay stable. req_data changes are ignored; data is latched at grant.
  - If out_sync=1: next cycle out_notify=0, req_sync[g]=1 (single pulse), xfer_count+1, rr pointer=(g+1) mod N_REQ; go to ACK.
  - If out_sync=0: stay in SEND indefinitely. There is no timeout.
- State ACK:
  - One cycle. req_sync[g] is high this cycle only.
  - New req_notify is not arbitrated, so the winner's stale notify cannot be re-granted.
  - Next state is IDLE; req_sync returns to 0.
- Latency:
  - notify sampled at cycle t gives out_notify at t+1.
  - Acceptance at cycle a gives req_sync at a+1.
  - Minimum spacing between grants is 3 cycles (IDLE, SEND, ACK).
- Requester dropping notify while waiting: the grant is already latched, so the transfer completes and req_sync still pulses.
- Simultaneous requests: exactly one grant per IDLE cycle; the others wait. Fairness: a continuously requesting requester is served within N_REQ grants.
- out_sync while out_notify=0 is ignored.
- At most one req_sync bit is ever set. req_sync is never set outside ACK.
- xfer_count wraps from 2^CNT_W-1 to 0.
- grant_id holds its last value in IDLE.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req_notify=4'b1111 -> out_notify=0, req_sync=0, xfer_count=0, busy=0; after rst=1, first grant goes to requester 0.
- Single transfer: req_notify=4'b0100, data[2]=0xDEADBEEF, out_sync=1 -> out_notify=1 with out_data=0xDEADBEEF one cycle later; req_sync=4'b0100 the following cycle; xfer_count=1; grant_id=2.
- Backpressure: out_sync=0 for 5 cycles, data[1] changed to 0x5 meanwhile -> out_notify and out_data=original value stable for all 5 cycles; no req_sync until one cycle after out_sync=1.
- Round-robin fairness: all four requesters notify continuously, out_sync=1 -> grant order 0,1,2,3,0; one req_sync per grant; consecutive grants 3 cycles apart.
- Reset mid-SEND: rst=0 while in SEND with out_sync=0 -> next cycle out_notify=0, no req_sync pulse, xfer_count unchanged.
- Counter wrap: CNT_W=4, run 17 transfers -> xfer_count goes 15 then 0, ends at 1.

Source files
------------

// File: rtl/blocking_port_arbiter.sv
// rtl/blocking_port_arbiter.sv - round-robin arbiter sharing one blocking output port
module blocking_port_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic [N_REQ-1:0]           req_notify,
    output logic [N_REQ-1:0]           req_sync,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_notify,
    input  logic                       out_sync,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic [CNT_W-1:0]           xfer_count
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [GW-1:0]       rr_ptr, rr_n;
    logic [GW-1:0]       grant_n;
    logic [DATA_W-1:0]   data_n;
    logic                notify_n;
    logic [N_REQ-1:0]    sync_n;
    logic [CNT_W-1:0]    cnt_n;
    logic                busy_n;
    logic                found;
    logic [GW-1:0]       pick;
    int                  idx;

    // Next-state and next-output logic; every output is computed here and registered below
    always_comb begin
        state_n  = state;
        rr_n     = rr_ptr;
        grant_n  = grant_id;
        data_n   = out_data;
        notify_n = out_notify;
        sync_n   = '0;
        cnt_n    = xfer_count;
        found    = 1'b0;
        pick     = '0;
        idx      = 0;

        // First set notify bit searching upward from the round-robin pointer, wrapping
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_notify[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    grant_n  = pick;
                    data_n   = req_data[int'(pick)*DATA_W +: DATA_W];
                    notify_n = 1'b1;
                    state_n  = SEND;
                end
            end
            SEND: begin
                // Data was latched at grant; only downstream acceptance moves us on
                if (out_sync) begin
                    notify_n         = 1'b0;
                    sync_n[grant_id] = 1'b1;
                    cnt_n            = xfer_count + 1'b1;
                    rr_n             = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state_n          = ACK;
                end
            end
            ACK: begin
                // Requests are not looked at here so the winner's stale notify is not regranted
                state_n = IDLE;
            end
            default: begin
                state_n  = IDLE;
                notify_n = 1'b0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            out_data   <= '0;
            out_notify <= 1'b0;
            req_sync   <= '0;
            xfer_count <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            rr_ptr     <= rr_n;
            grant_id   <= grant_n;
            out_data   <= data_n;
            out_notify <= notify_n;
            req_sync   <= sync_n;
            xfer_count <= cnt_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_blocking_port_arbiter.sv
// tb/tb_blocking_port_arbiter.sv - directed self-checking bench for blocking_port_arbiter
module tb_blocking_port_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic                    clk;
    logic                    rst;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_notify;
    logic [N_REQ-1:0]        req_sync;
    logic [DATA_W-1:0]       out_data;
    logic                    out_notify;
    logic                    out_sync;
    logic [1:0]              grant_id;
    logic                    busy;
    logic [CNT_W-1:0]        xfer_count;

    int vectors = 0;
    int errors  = 0;
    int exp_cnt = 0;
    logic [31:0] words [4];

    blocking_port_arbiter #(
        .N_REQ (N_REQ),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_notify(req_notify),
        .req_sync  (req_sync),
        .out_data  (out_data),
        .out_notify(out_notify),
        .out_sync  (out_sync),
        .grant_id  (grant_id),
        .busy      (busy),
        .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [31:0] v);
        req_data[i*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        rst        = 1'b0;
        req_notify = 4'b1111;
        out_sync   = 1'b0;
        req_data   = '0;
        words[0] = 32'hA0A0_0000;
        words[1] = 32'hB1B1_1111;
        words[2] = 32'hC2C2_2222;
        words[3] = 32'hD3D3_3333;
        for (int i = 0; i < 4; i++) set_word(i, words[i]);

        // Reset held two cycles with all requesters notifying
        step();
        step();
        chk("rst_out_notify", 32'(out_notify), 32'd0);
        chk("rst_req_sync",   32'(req_sync),   32'd0);
        chk("rst_xfer_count", 32'(xfer_count), 32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_grant_id",   32'(grant_id),   32'd0);
        chk("rst_out_data",   out_data,        32'd0);

        // First grant after reset goes to requester 0
        rst = 1'b1;
        step();
        chk("first_grant_id",   32'(grant_id),   32'd0);
        chk("first_out_notify", 32'(out_notify), 32'd1);
        chk("first_out_data",   out_data,        words[0]);
        chk("first_busy",       32'(busy),       32'd1);
        out_sync = 1'b1;
        step();
        exp_cnt = 1;
        chk("first_req_sync", 32'(req_sync),   32'b0001);
        chk("first_count",    32'(xfer_count), 32'(exp_cnt));
        chk("first_ack_busy", 32'(busy),       32'd1);
        req_notify = 4'b0000;
        out_sync   = 1'b0;
        step();
        chk("first_idle_sync", 32'(req_sync), 32'd0);
        chk("first_idle_busy", 32'(busy),     32'd0);

        // Single transfer from requester 2 (pointer now 1)
        set_word(2, 32'hDEADBEEF);
        req_notify = 4'b0100;
        out_sync   = 1'b1;
        step();
        chk("single_out_notify", 32'(out_notify), 32'd1);
        chk("single_out_data",   out_data,        32'hDEADBEEF);
        chk("single_grant_id",   32'(grant_id),   32'd2);
        step();
        exp_cnt = 2;
        chk("single_req_sync",   32'(req_sync),   32'b0100);
        chk("single_count",      32'(xfer_count), 32'(exp_cnt));
        chk("single_ack_notify", 32'(out_notify), 32'd0);
        req_notify = 4'b0000;
        step();
        chk("single_idle_sync",  32'(req_sync),   32'd0);

        // out_sync while idle with no notify is ignored
        step();
        chk("idle_sync_notify", 32'(out_notify), 32'd0);
        chk("idle_sync_count",  32'(xfer_count), 32'(exp_cnt));
        chk("idle_grant_hold",  32'(grant_id),   32'd2);

        // Backpressure on requester 1 (pointer now 3), data changed while waiting
        set_word(1, 32'h1111_2222);
        req_notify = 4'b0010;
        out_sync   = 1'b0;
        step();
        chk("bp_grant_id", 32'(grant_id), 32'd1);
        set_word(1, 32'h0000_0005);
        for (int c = 0; c < 5; c++) begin
            chk("bp_out_notify", 32'(out_notify), 32'd1);
            chk("bp_out_data",   out_data,        32'h1111_2222);
            chk("bp_req_sync",   32'(req_sync),   32'd0);
            step();
        end
        out_sync = 1'b1;
        chk("bp_pre_sync", 32'(req_sync), 32'd0);
        step();
        exp_cnt = 3;
        chk("bp_req_sync_pulse", 32'(req_sync),   32'b0010);
        chk("bp_count",          32'(xfer_count), 32'(exp_cnt));
        chk("bp_ack_notify",     32'(out_notify), 32'd0);
        req_notify = 4'b0000;
        out_sync   = 1'b0;
        step();

        // Reset in SEND abandons the word (pointer now 2, so 0 is found by wrapping)
        req_notify = 4'b0001;
        step();
        chk("rs_grant_id",   32'(grant_id),   32'd0);
        chk("rs_out_notify", 32'(out_notify), 32'd1);
        rst = 1'b0;
        step();
        exp_cnt = 0;
        chk("rs_out_notify_clr", 32'(out_notify), 32'd0);
        chk("rs_req_sync",       32'(req_sync),   32'd0);
        chk("rs_count",          32'(xfer_count), 32'(exp_cnt));
        chk("rs_busy",           32'(busy),       32'd0);
        rst        = 1'b1;
        req_notify = 4'b0000;
        step();
        chk("rs_no_pulse", 32'(req_sync), 32'd0);

        // Round robin: all requesters notify continuously with a ready consumer
        for (int i = 0; i < 4; i++) set_word(i, words[i]);
        req_notify = 4'b1111;
        out_sync   = 1'b1;
        for (int g = 0; g < 5; g++) begin
            step();
            chk("rr_grant_id",   32'(grant_id),   32'(g % 4));
            chk("rr_out_notify", 32'(out_notify), 32'd1);
            chk("rr_out_data",   out_data,        words[g % 4]);
            step();
            exp_cnt = (exp_cnt + 1) % 16;
            chk("rr_req_sync",   32'(req_sync),   32'(1 << (g % 4)));
            chk("rr_count",      32'(xfer_count), 32'(exp_cnt));
            if (g == 4) req_notify = 4'b0000;
            step();
            chk("rr_idle_notify", 32'(out_notify), 32'd0);
            chk("rr_idle_sync",   32'(req_sync),   32'd0);
        end

        // Counter wrap: twelve more transfers bring the total since reset to 17
        for (int t = 0; t < 12; t++) begin
            req_notify = 4'b1000;
            step();
            chk("wrap_grant_id", 32'(grant_id), 32'd3);
            step();
            exp_cnt = (exp_cnt + 1) % 16;
            chk("wrap_count",    32'(xfer_count), 32'(exp_cnt));
            chk("wrap_req_sync", 32'(req_sync),   32'b1000);
            req_notify = 4'b0000;
            step();
        end
        chk("wrap_final_count", 32'(xfer_count), 32'd1);
        chk("wrap_grant_hold",  32'(grant_id),   32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
